ex_muldiv_ctrl: RTL and testbench

- Multi-cycle controller and iterative engine for M-extension ops (MUL, MULHU, DIVU, REMU) issued in the EX stage of the 5-stage pipeline.
- Detects an M-op in EX, sequences a 32-iteration shift-add multiplier or restoring divider, and holds the front of the pipeline while it runs.
- While busy, bubbles EX/MEM. When finished, presents the result so the EX/MEM register captures it in place of the ALU result.

---
 rtl/ex_muldiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage controller and iterative engine for MUL, MULHU,
// DIVU and REMU. One M-op is accepted from IDLE, computed one bit per cycle
// in BUSY, and its result is presented for a single cycle in DONE while the
// front of the pipeline is held and EX/MEM is bubbled.
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDivE,
    input  logic [1:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMD,
    output logic            BubbleM,
    output logic            MDValidE,
    output logic [XLEN-1:0] MDResultE
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Op encoding: bit 1 selects divide, bit 0 selects the upper half of the
    // accumulator (MULHU high word, REMU remainder).
    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;       // multiplicand
    logic [XLEN-1:0]     b_q, b_d;       // multiplier (shifts right) or divisor
    logic [2*XLEN-1:0]   acc_q, acc_d;   // mul: {hi, lo} product; div: {rem, quo}
    logic [XLEN-1:0]     res_q, res_d;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_rem_sh;
    logic [XLEN:0]       div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   iter_next;

    // Datapath for one iteration of either engine.
    always_comb begin
        // Shift-add: add the multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder,
        // subtract the divisor and keep the difference when it does not borrow.
        div_rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff   = div_rem_sh - {1'b0, b_q};
        div_ge     = ~div_diff[XLEN];
        div_next   = div_ge ? {div_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1}
                            : {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        iter_next = op_q[1] ? div_next : mul_next;
    end

    // Next-state, register updates and pipeline control outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        StallMD  = 1'b0;
        MDValidE = 1'b0;

        case (state_q)
            S_IDLE: begin
                StallMD = MulDivE & ~FlushE;
                if (MulDivE && !FlushE) begin
                    op_d    = MulDivOpE;
                    a_d     = SrcAE;
                    b_d     = SrcBE;
                    count_d = '0;
                    acc_d   = MulDivOpE[1] ? {{XLEN{1'b0}}, SrcAE} : '0;
                    if (MulDivOpE[1] && (SrcBE == '0)) begin
                        // Divide by zero finishes immediately with the
                        // architecturally defined quotient/remainder.
                        state_d = S_DONE;
                        res_d   = MulDivOpE[0] ? SrcAE : '1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                StallMD = ~FlushE;
                acc_d   = iter_next;
                if (!op_q[1]) begin
                    b_d = b_q >> 1;
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = S_DONE;
                    if (!FlushE) begin
                        res_d = op_q[0] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
                    end
                end
            end

            S_DONE: begin
                // MulDivE seen here belongs to the finishing instruction.
                MDValidE = ~FlushE;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (FlushE) begin
            state_d = S_IDLE;
        end
    end

    assign BubbleM   = StallMD & ~FlushE;
    assign MDResultE = res_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed vector table, random ops
// against an arithmetic reference model, and hand-written flush, reset and
// back-to-back sequences.
module tb_ex_muldiv_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            MulDivE;
    logic [1:0]      MulDivOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMD;
    logic            BubbleM;
    logic            MDValidE;
    logic [XLEN-1:0] MDResultE;

    ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .MulDivE   (MulDivE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .StallMD   (StallMD),
        .BubbleM   (BubbleM),
        .MDValidE  (MDValidE),
        .MDResultE (MDResultE)
    );

    always #5 clk = ~clk;

    int total   = 0;
    int passed  = 0;
    int bub_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] stalls;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics computed with plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one M-op (caller is just after a rising edge), hold it in EX until
    // MDValidE, count stall cycles, and release it in the cycle after DONE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int stalls, output logic [31:0] res,
                          output bit ok);
        stalls    = 0;
        ok        = 1'b0;
        res       = 'x;
        MulDivE   = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (BubbleM !== StallMD) bub_err++;
            if (MDValidE === 1'b1) begin
                res = MDResultE;
                ok  = 1'b1;
                if (StallMD !== 1'b0) bub_err++;
                break;
            end
            if (StallMD === 1'b1) stalls++;
            @(posedge clk);
            #1;
            if (scramble) begin
                SrcAE = $urandom;
                SrcBE = $urandom;
            end
        end
        @(posedge clk);
        #1;
        MulDivE = 1'b0;
    endtask

    int          stalls;
    logic [31:0] res;
    bit          ok;
    bit          seen;

    initial begin
        vecs[0] = '{2'b00, 32'd7,         32'd6,         32'h0000_002A, 32'd33};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd33};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'd33};
        vecs[3] = '{2'b10, 32'd100,       32'd7,         32'h0000_000E, 32'd33};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'd33};
        vecs[5] = '{2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd1};
        vecs[6] = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'd1};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'd33};
        vecs[8] = '{2'b10, 32'd7,         32'd100,       32'h0000_0000, 32'd33};
        vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'd33};

        reset     = 1'b1;
        MulDivE   = 1'b0;
        MulDivOpE = 2'b00;
        SrcAE     = '0;
        SrcBE     = '0;
        FlushE    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_stall",  {31'b0, StallMD},  32'd0);
        check("reset_bubble", {31'b0, BubbleM},  32'd0);
        check("reset_valid",  {31'b0, MDValidE}, 32'd0);
        check("reset_result", MDResultE,         32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // A flushed M-op in IDLE must not stall.
        MulDivE = 1'b1;
        FlushE  = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", {31'b0, StallMD}, 32'd0);
        @(posedge clk);
        #1;
        MulDivE = 1'b0;
        FlushE  = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, stalls, res, ok);
            check($sformatf("vec%0d_done", i),   {31'b0, ok},   32'd1);
            check($sformatf("vec%0d_result", i), res,           vecs[i].res);
            check($sformatf("vec%0d_stalls", i), 32'(stalls),   vecs[i].stalls);
            @(negedge clk);
            check($sformatf("vec%0d_after_stall", i), {31'b0, StallMD}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Random ops against the reference; operands change while BUSY.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op(op, a, b, 1'b1, stalls, res, ok);
            check($sformatf("rand%0d_result", i), res, model(op, a, b));
            check($sformatf("rand%0d_stalls", i), 32'(stalls),
                  (op[1] && b == 0) ? 32'd1 : 32'd33);
        end

        // Flush at BUSY count 10: no stall in the flush cycle, no result.
        MulDivE   = 1'b1;
        MulDivOpE = 2'b00;
        SrcAE     = 32'd3;
        SrcBE     = 32'd5;
        repeat (11) @(posedge clk);
        #1;
        FlushE = 1'b1;
        @(negedge clk);
        check("flush_stall",  {31'b0, StallMD},  32'd0);
        check("flush_bubble", {31'b0, BubbleM},  32'd0);
        check("flush_valid",  {31'b0, MDValidE}, 32'd0);
        @(posedge clk);
        #1;
        FlushE  = 1'b0;
        MulDivE = 1'b0;
        seen    = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MDValidE !== 1'b0 || StallMD !== 1'b0) seen = 1'b1;
        end
        check("flush_quiet", {31'b0, seen}, 32'd0);
        @(posedge clk);
        #1;
        run_op(2'b00, 32'd2, 32'd2, 1'b0, stalls, res, ok);
        check("post_flush_result", res,         32'd4);
        check("post_flush_stalls", 32'(stalls), 32'd33);

        // Reset at BUSY count 20: IDLE next cycle, result register cleared.
        MulDivE   = 1'b1;
        MulDivOpE = 2'b00;
        SrcAE     = 32'h1234;
        SrcBE     = 32'h10;
        repeat (21) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        MulDivE = 1'b0;
        @(negedge clk);
        check("midreset_stall",  {31'b0, StallMD},  32'd0);
        check("midreset_valid",  {31'b0, MDValidE}, 32'd0);
        check("midreset_result", MDResultE,         32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (MDValidE !== 1'b0) seen = 1'b1;
        end
        check("midreset_quiet", {31'b0, seen}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back: second op issued in the cycle right after DONE.
        run_op(2'b00, 32'd2, 32'd3, 1'b0, stalls, res, ok);
        check("b2b_first_result", res,         32'd6);
        check("b2b_first_stalls", 32'(stalls), 32'd33);
        run_op(2'b10, 32'd9, 32'd3, 1'b0, stalls, res, ok);
        check("b2b_second_result", res,         32'd3);
        check("b2b_second_stalls", 32'(stalls), 32'd33);

        check("bubble_tracks_stall", 32'(bub_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
